// File: rtl/relogio_pkg.sv
// Shared definitions for the clock's mode encoding and mode sequencing helpers.
package relogio_pkg;

  localparam int unsigned MODO_W = 2;

  localparam logic [MODO_W-1:0] MODO_RODANDO = 2'b00;
  localparam logic [MODO_W-1:0] MODO_AJ_MIN  = 2'b01;
  localparam logic [MODO_W-1:0] MODO_AJ_HR   = 2'b10;

  typedef enum logic [MODO_W-1:0] {
    StRodando = MODO_RODANDO,
    StAjMin   = MODO_AJ_MIN,
    StAjHr    = MODO_AJ_HR
  } modo_e;

  function automatic logic modo_valido(modo_e m);
    return (m == StRodando) || (m == StAjMin) || (m == StAjHr);
  endfunction

  // Any unknown encoding falls back to run mode.
  function automatic modo_e proximo_modo(modo_e m);
    modo_e r;
    unique case (m)
      StRodando: r = StAjMin;
      StAjMin:   r = StAjHr;
      default:   r = StRodando;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ajuste_controlador_if.sv
// Button inputs and adjust-mode control outputs of the clock front-end controller.
interface ajuste_controlador_if;
  import relogio_pkg::*;

  logic              btn_modo;
  logic              btn_inc;
  logic [MODO_W-1:0] modo;
  logic              ajuste_min;
  logic              ajuste_hr;
  logic              ajuste_any;
  logic              inc_pulse;
  logic              blink;
  logic              timeout_evt;

  modport master (
    output btn_modo, btn_inc,
    input  modo, ajuste_min, ajuste_hr, ajuste_any, inc_pulse, blink, timeout_evt
  );

  modport slave (
    input  btn_modo, btn_inc,
    output modo, ajuste_min, ajuste_hr, ajuste_any, inc_pulse, blink, timeout_evt
  );

endinterface

// File: rtl/debounce_botao.sv
// Two-flop synchroniser, mismatch-count debouncer and registered rising-edge pulse
// for one raw push button.
module debounce_botao #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The count only survives while every cycle disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      cnt_q       <= '0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  // level is delayed one cycle so it rises together with press.
  assign level = level_dly_q;
  assign press = press_q;

endmodule

// File: rtl/ajuste_controlador.sv
// Adjust-mode front end: mode FSM, increment auto-repeat, inactivity timeout and
// blink divider, driven by the two debounced buttons. All outputs are registered.
module ajuste_controlador
  import relogio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned HOLD_CYC     = 8,
  parameter int unsigned REPEAT_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC  = 64,
  parameter int unsigned BLINK_CYC    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  ajuste_controlador_if.slave bus
);

  localparam int unsigned RepMax = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam int unsigned ToW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_CYC + 1);

  logic modo_press, modo_level_unused;
  logic inc_press, inc_level;

  debounce_botao #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db_modo (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bus.btn_modo),
    .level(modo_level_unused),
    .press(modo_press)
  );

  debounce_botao #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db_inc (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bus.btn_inc),
    .level(inc_level),
    .press(inc_press)
  );

  modo_e             state_q, state_d;
  logic              rep_active_q, rep_active_d;
  logic              rep_first_q, rep_first_d;
  logic [RepW-1:0]   rep_cnt_q, rep_cnt_d, rep_lim;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;
  logic              inc_pulse_q, inc_pulse_d;
  logic              timeout_evt_q, timeout_evt_d;
  logic              ajuste_min_q, ajuste_hr_q, ajuste_any_q;
  logic              adjust, inc_fire, mode_change;

  always_comb begin
    state_d       = state_q;
    rep_active_d  = rep_active_q;
    rep_first_d   = rep_first_q;
    rep_cnt_d     = rep_cnt_q;
    to_cnt_d      = to_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_d       = blink_q;
    inc_pulse_d   = 1'b0;
    timeout_evt_d = 1'b0;
    inc_fire      = 1'b0;
    mode_change   = 1'b0;
    rep_lim       = rep_first_q ? RepW'(HOLD_CYC - 1) : RepW'(REPEAT_CYC - 1);
    adjust        = (state_q == StAjMin) || (state_q == StAjHr);

    // A mode press outranks everything, including an inc press in the same cycle.
    if (modo_press || !modo_valido(state_q)) begin
      state_d     = proximo_modo(state_q);
      mode_change = 1'b1;
    end else if (adjust) begin
      if (inc_press) begin
        inc_fire     = 1'b1;
        rep_active_d = 1'b1;
        rep_first_d  = 1'b1;
        rep_cnt_d    = '0;
      end else if (rep_active_q && inc_level) begin
        if (rep_cnt_q == rep_lim) begin
          inc_fire    = 1'b1;
          rep_first_d = 1'b0;
          rep_cnt_d   = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end else begin
        rep_active_d = 1'b0;
        rep_cnt_d    = '0;
      end

      if (inc_fire) begin
        inc_pulse_d = 1'b1;
        to_cnt_d    = '0;
      end else if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
        state_d       = StRodando;
        timeout_evt_d = 1'b1;
        mode_change   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (mode_change) begin
      rep_active_d = 1'b0;
      rep_first_d  = 1'b0;
      rep_cnt_d    = '0;
      to_cnt_d     = '0;
      blink_cnt_d  = '0;
      blink_d      = (state_d != StRodando);
    end else if (adjust) begin
      if (blink_cnt_q == BlinkW'(BLINK_CYC - 1)) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRodando;
      rep_active_q  <= 1'b0;
      rep_first_q   <= 1'b0;
      rep_cnt_q     <= '0;
      to_cnt_q      <= '0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
      inc_pulse_q   <= 1'b0;
      timeout_evt_q <= 1'b0;
      ajuste_min_q  <= 1'b0;
      ajuste_hr_q   <= 1'b0;
      ajuste_any_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rep_active_q  <= rep_active_d;
      rep_first_q   <= rep_first_d;
      rep_cnt_q     <= rep_cnt_d;
      to_cnt_q      <= to_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
      inc_pulse_q   <= inc_pulse_d;
      timeout_evt_q <= timeout_evt_d;
      ajuste_min_q  <= (state_d == StAjMin);
      ajuste_hr_q   <= (state_d == StAjHr);
      ajuste_any_q  <= (state_d == StAjMin) || (state_d == StAjHr);
    end
  end

  assign bus.modo        = state_q;
  assign bus.ajuste_min  = ajuste_min_q;
  assign bus.ajuste_hr   = ajuste_hr_q;
  assign bus.ajuste_any  = ajuste_any_q;
  assign bus.inc_pulse   = inc_pulse_q;
  assign bus.blink       = blink_q;
  assign bus.timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_ajuste_controlador.sv
// Directed bench for ajuste_controlador: reset, bounce, mode sequence, auto-repeat,
// simultaneous presses, timeout and its restart.
module tb_ajuste_controlador;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   pulses;
  logic exp_p;

  always #5 clk = ~clk;

  ajuste_controlador_if bus ();

  ajuste_controlador dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Raw rise sampled at edge 0; the mode changes at edge 7.
  task automatic press_modo(input logic [1:0] antes, input logic [1:0] depois);
    bus.btn_modo = 1'b1;
    tick(7);
    chk("modo_before_accept", 32'(bus.modo), 32'(antes));
    tick(1);
    chk("modo_after_accept", 32'(bus.modo), 32'(depois));
  endtask

  task automatic release_modo();
    bus.btn_modo = 1'b0;
    tick(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_modo = 1'b0;
    bus.btn_inc  = 1'b0;

    // 1: reset with buttons toggling
    for (int i = 0; i < 6; i++) begin
      bus.btn_modo = (i % 2 == 0);
      bus.btn_inc  = (i % 2 == 1);
      tick();
    end
    chk("reset_modo", 32'(bus.modo), 0);
    chk("reset_outs", 32'({bus.ajuste_min, bus.ajuste_hr, bus.ajuste_any, bus.inc_pulse,
                           bus.blink, bus.timeout_evt}), 0);
    bus.btn_modo = 1'b0;
    bus.btn_inc  = 1'b0;
    tick(2);
    #2 rst_n = 1'b1;
    tick(10);
    chk("post_reset_modo", 32'(bus.modo), 0);
    chk("post_reset_blink", 32'(bus.blink), 0);

    // 2: bounce then stable rise, one transition 00->01
    bus.btn_modo = 1'b1; tick();
    bus.btn_modo = 1'b0; tick();
    bus.btn_modo = 1'b1; tick();
    bus.btn_modo = 1'b0; tick();
    press_modo(2'd0, 2'd1);
    chk("min_flags", 32'({bus.ajuste_min, bus.ajuste_hr, bus.ajuste_any}), 32'b101);
    chk("blink_entry", 32'(bus.blink), 1);
    release_modo();
    chk("modo_held_01", 32'(bus.modo), 1);

    // 3: sequence 01 -> 10 -> 00
    press_modo(2'd1, 2'd2);
    chk("hr_flags", 32'({bus.ajuste_min, bus.ajuste_hr, bus.ajuste_any}), 32'b011);
    release_modo();
    press_modo(2'd2, 2'd0);
    chk("run_flags", 32'({bus.ajuste_min, bus.ajuste_hr, bus.ajuste_any}), 32'b000);
    chk("run_blink", 32'(bus.blink), 0);
    release_modo();

    // 4a: inc held in run mode gives nothing
    bus.btn_inc = 1'b1;
    pulses = 0;
    repeat (40) begin
      tick();
      if (bus.inc_pulse) pulses++;
    end
    chk("run_inc_pulses", 32'(pulses), 0);
    bus.btn_inc = 1'b0;
    tick(8);

    // 4b: auto-repeat in 01, release at +24 stops after the +28 pulse
    press_modo(2'd0, 2'd1);
    release_modo();
    bus.btn_inc = 1'b1;
    tick(7);
    chk("inc_before_accept", 32'(bus.inc_pulse), 0);
    tick();
    chk("inc_press_pulse", 32'(bus.inc_pulse), 1);
    for (int rel = 1; rel <= 40; rel++) begin
      tick();
      exp_p = (rel == 8) || (rel == 12) || (rel == 16) || (rel == 20) || (rel == 24) ||
              (rel == 28);
      chk($sformatf("repeat_rel%0d", rel), 32'(bus.inc_pulse), 32'(exp_p));
      if (rel == 24) bus.btn_inc = 1'b0;
    end

    // 5: simultaneous modo+inc in 01
    bus.btn_modo = 1'b1;
    bus.btn_inc  = 1'b1;
    tick(7);
    chk("sim_modo_before", 32'(bus.modo), 1);
    tick();
    chk("sim_modo_after", 32'(bus.modo), 2);
    chk("sim_inc_suppressed", 32'(bus.inc_pulse), 0);
    pulses = 0;
    repeat (20) begin
      tick();
      if (bus.inc_pulse) pulses++;
    end
    chk("sim_no_repeat", 32'(pulses), 0);
    bus.btn_modo = 1'b0;
    bus.btn_inc  = 1'b0;

    // 6a: press accepted at cycle 63 of 10 restarts the timeout
    tick(35);
    bus.btn_inc = 1'b1;
    tick(5);
    bus.btn_inc = 1'b0;
    tick(2);
    chk("late_inc_before", 32'(bus.inc_pulse), 0);
    tick();
    chk("late_inc_pulse", 32'(bus.inc_pulse), 1);
    chk("late_inc_modo", 32'(bus.modo), 2);
    tick();
    chk("restart_modo_64", 32'(bus.modo), 2);
    chk("restart_no_evt", 32'(bus.timeout_evt), 0);
    pulses = 0;
    repeat (62) begin
      tick();
      if (bus.inc_pulse || bus.timeout_evt) pulses++;
    end
    chk("restart_quiet", 32'(pulses), 0);
    chk("restart_modo_126", 32'(bus.modo), 2);
    tick();
    chk("to_modo", 32'(bus.modo), 0);
    chk("to_evt", 32'(bus.timeout_evt), 1);
    chk("to_inc", 32'(bus.inc_pulse), 0);
    tick();
    chk("to_evt_one_cycle", 32'(bus.timeout_evt), 0);
    chk("to_flags", 32'({bus.ajuste_any, bus.blink}), 0);

    // 6b: idle in 10 for 64 cycles, with blink phase on entry
    press_modo(2'd0, 2'd1);
    release_modo();
    press_modo(2'd1, 2'd2);
    bus.btn_modo = 1'b0;
    chk("blink_e0", 32'(bus.blink), 1);
    tick();
    chk("blink_e1", 32'(bus.blink), 1);
    tick();
    chk("blink_e2", 32'(bus.blink), 0);
    tick(61);
    chk("idle_modo_63", 32'(bus.modo), 2);
    chk("idle_evt_63", 32'(bus.timeout_evt), 0);
    tick();
    chk("idle_modo_64", 32'(bus.modo), 0);
    chk("idle_evt_64", 32'(bus.timeout_evt), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
